// File: rtl/c64_loader_pkg.sv
// Shared types and constants for the C64 file loader: file type codes, loader
// states, FIFO entry layout, buffer defaults and header signature strings.
package c64_loader_pkg;

  typedef enum logic [2:0] {
    FT_NONE = 3'd0,
    FT_PRG  = 3'd1,
    FT_T64  = 3'd2,
    FT_CRT  = 3'd3,
    FT_TAP  = 3'd4
  } file_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN
  } load_state_e;

  typedef struct packed {
    logic [24:0] offset;
    logic [7:0]  data;
  } fifo_entry_t;

  localparam logic [24:0] BUFFER_BASE_DEF = 25'h200000;
  localparam logic [24:0] MAX_SIZE_DEF    = 25'h100000;

  // First character of each string sits in the most significant byte.
  localparam logic [127:0] SIG_CRT = "C64 CARTRIDGE   ";
  localparam logic [95:0]  SIG_TAP = "C64-TAPE-RAW";
  localparam logic [23:0]  SIG_T64 = "C64";

endpackage

// File: rtl/loader_byte_fifo.sv
// First-word-fall-through FIFO of {offset, byte} entries between the IO
// strobe side and the SDRAM write port. DEPTH must be a power of 2, >= 2.
module loader_byte_fifo
  import c64_loader_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  fifo_entry_t              wr_entry,
  input  logic                     pop,
  output fifo_entry_t              rd_entry,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  fifo_entry_t       mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign rd_entry = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/c64_file_loader.sv
// Streams a downloaded file into the SDRAM buffer and classifies it on completion.
// Optional macro C64_LOADER_SIGNATURE_EN adds header capture and CRT/TAP/T64 detection.
module c64_file_loader
  import c64_loader_pkg::*;
#(
  parameter logic [24:0] BUFFER_BASE = BUFFER_BASE_DEF,
  parameter logic [24:0] MAX_SIZE    = MAX_SIZE_DEF,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic        clk32,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_data,
  output logic        ioctl_wait,
  output logic        buf_req,
  output logic [24:0] buf_addr,
  output logic [7:0]  buf_data,
  input  logic        buf_ack,
  output logic [2:0]  file_type,
  output logic [24:0] file_size,
  output logic        load_done,
  output logic        load_error
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  load_state_e  state_q, state_d;
  logic         start, finish;
  logic         dl_q, dl_rise, dl_fall;
  logic         pend_q;
  logic [24:0]  offset_q;
  logic [24:0]  wr_cnt_q;
  logic         err_q;
  file_type_e   ft_q, ft_result;
  logic [24:0]  size_q;
  logic         done_q;
  logic         wait_q;

  logic         wr_take, over, push, pop, commit;
  fifo_entry_t  wr_entry, rd_entry;
  logic [CW-1:0] fifo_count, occ_nxt;
  logic         fifo_full, fifo_empty;

  assign dl_rise  = ioctl_download && !dl_q;
  assign dl_fall  = !ioctl_download && dl_q;
  assign wr_take  = (state_q == ST_LOAD) && ioctl_wr;
  assign over     = (offset_q >= MAX_SIZE);
  assign push     = wr_take && !over && !fifo_full;
  assign pop      = !buf_req && !fifo_empty;
  assign commit   = buf_req && buf_ack;
  assign wr_entry = '{offset: offset_q, data: ioctl_data};
  assign occ_nxt  = fifo_count + CW'(push) - CW'(pop);

  assign ioctl_wait = wait_q;
  assign file_type  = ft_q;
  assign file_size  = size_q;
  assign load_done  = done_q;
  assign load_error = err_q;

  loader_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk32),
    .rst_n    (reset_n),
    .push     (push),
    .wr_entry (wr_entry),
    .pop      (pop),
    .rd_entry (rd_entry),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // A download edge remembered during DRAIN restarts the load straight from IDLE.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dl_rise || pend_q) begin
          start   = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (dl_fall) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fifo_empty && !buf_req) begin
          finish  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef C64_LOADER_SIGNATURE_EN
  logic [127:0] hdr_q;

  // Header bytes are taken as they enter the FIFO, byte 0 in the top byte.
  always_ff @(posedge clk32) begin
    if (start) begin
      hdr_q <= '0;
    end else if (push) begin
      for (int i = 0; i < 16; i++) begin
        if (offset_q == 25'(i)) hdr_q[8*(15-i) +: 8] <= ioctl_data;
      end
    end
  end

  always_comb begin
    ft_result = FT_NONE;
    if (err_q)                                          ft_result = FT_NONE;
    else if (wr_cnt_q >= 25'd16 && hdr_q == SIG_CRT)    ft_result = FT_CRT;
    else if (wr_cnt_q >= 25'd12 && hdr_q[127:32] == SIG_TAP) ft_result = FT_TAP;
    else if (wr_cnt_q >= 25'd3 && hdr_q[127:104] == SIG_T64) ft_result = FT_T64;
    else if (wr_cnt_q >= 25'd2)                         ft_result = FT_PRG;
  end
`else
  always_comb begin
    ft_result = FT_NONE;
    if (!err_q && wr_cnt_q >= 25'd2) ft_result = FT_PRG;
  end
`endif

  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      dl_q     <= 1'b0;
      pend_q   <= 1'b0;
      offset_q <= '0;
      wr_cnt_q <= '0;
      err_q    <= 1'b0;
      ft_q     <= FT_NONE;
      size_q   <= '0;
      done_q   <= 1'b0;
      wait_q   <= 1'b0;
    end else begin
      dl_q   <= ioctl_download;
      wait_q <= (occ_nxt >= CW'(FIFO_DEPTH - 1));
      done_q <= finish;
      if (start) begin
        pend_q   <= 1'b0;
        offset_q <= '0;
        wr_cnt_q <= '0;
        err_q    <= 1'b0;
        ft_q     <= FT_NONE;
        size_q   <= '0;
      end else begin
        if (state_q == ST_DRAIN && dl_rise) pend_q <= 1'b1;
        // A byte lost to a full FIFO still consumes its offset.
        if (wr_take && !over) offset_q <= offset_q + 25'd1;
        if (wr_take && (over || fifo_full)) err_q <= 1'b1;
        if (commit) wr_cnt_q <= wr_cnt_q + 25'd1;
        if (finish) begin
          ft_q   <= ft_result;
          size_q <= wr_cnt_q;
        end
      end
    end
  end

  // SDRAM write port: hold the request until acked, then idle one cycle.
  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      buf_req  <= 1'b0;
      buf_addr <= '0;
      buf_data <= '0;
    end else if (buf_req) begin
      if (buf_ack) buf_req <= 1'b0;
    end else if (!fifo_empty) begin
      buf_req  <= 1'b1;
      buf_addr <= BUFFER_BASE + rd_entry.offset;
      buf_data <= rd_entry.data;
    end
  end

endmodule
